// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state
// encoding, and helpers that map an access to byte lanes.
//   f3_illegal  : funct3 not usable for the given direction
//   f3_misalign : address not naturally aligned for the access size
//   lane_be     : byte enables for an access at byte offset a
//   lane_wdata  : store data replicated into every lane of its size
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Stores have no unsigned forms, so any funct3[2]=1 store is illegal.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = we;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  // funct3[1:0] encodes the size for both signed and unsigned loads.
  function automatic logic f3_misalign(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    mis = 1'b0;
    case (f3[1:0])
      2'b01:   mis = a[0];
      2'b10:   mis = (a != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    be = '0;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] wd;
    wd = '0;
    case (f3[1:0])
      2'b00:   wd = {4{wdata[7:0]}};
      2'b01:   wd = {2{wdata[15:0]}};
      default: wd = wdata;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the LSU (master) and a memory responder (slave).
//   dmem_req/we/be/addr/wdata : request, held by the master until dmem_gnt
//   dmem_gnt                  : responder accepts the request this cycle
//   dmem_rvalid/dmem_rdata    : read data return for loads
interface load_store_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Load data alignment: picks the addressed byte/half out of the read word
// and sign- or zero-extends it according to funct3.
//   i_funct3    : load funct3 (B/H/W/BU/HU)
//   i_addr_lo   : byte offset within the word
//   i_rdata     : raw read word from memory
//   o_rdata_ext : extended result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_rdata_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext;

  always_comb begin
    w_byte      = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half      = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
    w_sext      = ~i_funct3[2];
    o_rdata_ext = i_rdata;
    case (i_funct3[1:0])
      2'b00:   o_rdata_ext = {{24{w_sext & w_byte[7]}}, w_byte};
      2'b01:   o_rdata_ext = {{16{w_sext & w_half[15]}}, w_half};
      default: o_rdata_ext = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV32I load/store from the MEM stage, issues a
// word-aligned request on the data-memory bus, returns aligned load data and
// reports misaligned/illegal accesses or responder timeouts.
//   clk, rst        : clock, synchronous active-high reset
//   req_*           : core request (valid/ready handshake)
//   resp_*          : one-cycle completion pulse with data and status
//   dmem            : data-memory bus (master side)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic        resp_err,
  load_store_unit_if.master dmem
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  lsu_state_e  r_state;
  lsu_state_e  w_next;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [29:0] r_waddr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_misalign;
  logic        r_err;
  logic [TW-1:0] r_timer;

  logic        w_illegal;
  logic        w_misalign;
  logic        w_timeout;
  logic [31:0] w_rdata_ext;

  lsu_align u_align (
    .i_funct3    (r_funct3),
    .i_addr_lo   (r_addr_lo),
    .i_rdata     (dmem.dmem_rdata),
    .o_rdata_ext (w_rdata_ext)
  );

  always_comb begin
    w_illegal  = f3_illegal(req_funct3, req_we);
    w_misalign = f3_misalign(req_funct3, req_addr[1:0]);
    w_timeout  = (r_timer == TMAX);
    w_next     = r_state;
    case (r_state)
      IDLE: if (req_valid) w_next = (w_illegal || w_misalign) ? RESP : REQ;
      // gnt wins over a simultaneous rvalid; read data is only taken in WAIT
      REQ: begin
        if (dmem.dmem_gnt)  w_next = r_we ? RESP : WAIT;
        else if (w_timeout) w_next = RESP;
      end
      WAIT: begin
        if (dmem.dmem_rvalid) w_next = RESP;
        else if (w_timeout)   w_next = RESP;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_funct3   <= '0;
      r_addr_lo  <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
      r_err      <= 1'b0;
      r_timer    <= '0;
    end else begin
      r_state <= w_next;
      // Every transition resets the timer, so it counts from 0 in REQ and WAIT.
      if (w_next != r_state)
        r_timer <= '0;
      else if (r_state == REQ || r_state == WAIT)
        r_timer <= r_timer + 1'b1;

      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_funct3   <= req_funct3;
            r_addr_lo  <= req_addr[1:0];
            r_waddr    <= req_addr[31:2];
            r_wdata    <= req_wdata;
            r_rdata    <= '0;
            r_err      <= w_illegal;
            r_misalign <= ~w_illegal & w_misalign;
          end
        end
        REQ: begin
          if (!dmem.dmem_gnt && w_timeout) r_err <= 1'b1;
        end
        WAIT: begin
          if (dmem.dmem_rvalid)  r_rdata <= w_rdata_ext;
          else if (w_timeout)    r_err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready       = (r_state == IDLE);
    resp_valid      = (r_state == RESP);
    resp_rdata      = (r_state == RESP) ? r_rdata : '0;
    resp_misalign   = (r_state == RESP) & r_misalign;
    resp_err        = (r_state == RESP) & r_err;
    dmem.dmem_req   = (r_state == REQ);
    dmem.dmem_we    = (r_state == REQ) & r_we;
    dmem.dmem_be    = (r_state == REQ) ? lane_be(r_funct3, r_addr_lo) : '0;
    dmem.dmem_addr  = (r_state == REQ) ? {r_waddr, 2'b00} : '0;
    dmem.dmem_wdata = (r_state == REQ && r_we) ? lane_wdata(r_funct3, r_wdata) : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic        resp_err;

  load_store_unit_if dmem_bus ();

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_misalign (resp_misalign),
    .resp_err      (resp_err),
    .dmem          (dmem_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Expected behaviour of the current transaction (cycle numbers are absolute)
  bit          m_valid = 1'b0;
  int          mA, mR, m_rf, m_rl, m_wf, m_wl;
  bit          m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;
  bit          m_mis, m_err;

  // Observations for literal checks
  int          cap_nreq, cap_nresp, cap_rcyc;
  logic [31:0] cap_rdata, cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  bit          cap_mis, cap_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic int sz_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit legal(input bit we, input logic [2:0] f3);
    return (sz_of(f3) != 0) && !(we && f3 >= 3'd4);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int a, input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * a);
    if (sz_of(f3) == 1) v = v & 32'hFF;
    if (sz_of(f3) == 2) v = v & 32'hFFFF;
    if (f3 == 3'd0 && v >= 32'd128)   v = v - 32'd256;
    if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
    return v;
  endfunction

  // Per-cycle comparison against the transaction model
  always @(negedge clk) begin
    if (chk_en) begin
      automatic int c = cyc;
      automatic bit busy    = m_valid && c > mA && c <= mR;
      automatic bit in_req  = m_valid && c >= m_rf && c <= m_rl;
      automatic bit is_resp = m_valid && c == mR;
      chk("req_ready", {31'b0, req_ready}, {31'b0, !busy});
      chk("dmem_req", {31'b0, dmem_bus.dmem_req}, {31'b0, in_req});
      if (in_req) begin
        chk("dmem_be", {28'b0, dmem_bus.dmem_be}, {28'b0, m_be});
        chk("dmem_addr", dmem_bus.dmem_addr, m_addr);
        chk("dmem_we", {31'b0, dmem_bus.dmem_we}, {31'b0, m_we});
        if (m_we) chk("dmem_wdata", dmem_bus.dmem_wdata, m_wdata);
      end
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, is_resp});
      chk("resp_rdata", resp_rdata, is_resp ? m_rdata : 32'h0);
      chk("resp_misalign", {31'b0, resp_misalign}, {31'b0, is_resp && m_mis});
      chk("resp_err", {31'b0, resp_err}, {31'b0, is_resp && m_err});
      if (dmem_bus.dmem_req) begin
        cap_nreq++;
        cap_be    = dmem_bus.dmem_be;
        cap_addr  = dmem_bus.dmem_addr;
        cap_wdata = dmem_bus.dmem_wdata;
      end
      if (resp_valid) begin
        cap_nresp++;
        cap_rcyc  = c;
        cap_rdata = resp_rdata;
        cap_mis   = resp_misalign;
        cap_err   = resp_err;
      end
    end
  end

  task automatic clear_inputs();
    req_valid = 1'b0;
    dmem_bus.dmem_gnt    = 1'b0;
    dmem_bus.dmem_rvalid = 1'b0;
  endtask

  // Drives one transaction starting in the current (idle) cycle; returns at
  // the first idle cycle after its response (or after an injected reset).
  task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] word,
                         input int g, input int r, input bit noise, input int rst_off);
    int a, sz, gnt_c, rv_c, rst_c, c;
    bit in_req, in_wait;
    a  = int'(addr[1:0]);
    sz = sz_of(f3);
    mA = cyc;
    cap_nreq = 0; cap_nresp = 0; cap_rcyc = -1;
    m_we = we;
    m_addr = addr & 32'hFFFF_FFFC;
    m_be = 4'(((1 << sz) - 1) << a);
    m_wdata = (sz == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
              (sz == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
    m_rdata = 32'h0; m_mis = 1'b0; m_err = 1'b0;
    m_rf = 1; m_rl = 0; m_wf = 1; m_wl = 0; gnt_c = -1; rv_c = -1;
    if (!legal(we, f3)) begin
      m_err = 1'b1; mR = mA + 1;
    end else if (a % sz != 0) begin
      m_mis = 1'b1; mR = mA + 1;
    end else if (g >= TO) begin
      m_rf = mA + 1; m_rl = mA + TO; mR = m_rl + 1; m_err = 1'b1;
    end else begin
      m_rf = mA + 1; m_rl = mA + 1 + g; gnt_c = m_rl;
      if (we) mR = m_rl + 1;
      else begin
        m_wf = m_rl + 1;
        if (r >= TO) begin
          m_wl = m_wf + TO - 1; mR = m_wl + 1; m_err = 1'b1;
        end else begin
          rv_c = m_wf + r; m_wl = rv_c; mR = rv_c + 1;
          m_rdata = model_load(f3, a, word);
        end
      end
    end
    m_valid = 1'b1;
    rst_c = (rst_off >= 0) ? m_wf + rst_off : -1;

    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0;
    forever begin
      @(posedge clk); #1;
      c = cyc;
      if (rst_c >= 0 && c == rst_c + 1) begin
        rst = 1'b0; m_valid = 1'b0; break;
      end
      if (c > mR) break;
      rst     = (c == rst_c);
      in_req  = c >= m_rf && c <= m_rl;
      in_wait = c >= m_wf && c <= m_wl;
      dmem_bus.dmem_gnt    = (c == gnt_c) || (!in_req && noise && ($urandom % 4 == 0));
      dmem_bus.dmem_rvalid = (c == rv_c) || (!in_wait && noise && ($urandom % 4 == 0));
      dmem_bus.dmem_rdata  = (c == rv_c) ? word : $urandom;
      // The core may present other requests while busy; they must be ignored
      req_valid  = noise && ($urandom % 2 == 1);
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
    end
    clear_inputs();
  endtask

  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0;
      dmem_bus.dmem_gnt    = 1'($urandom);
      dmem_bus.dmem_rvalid = 1'($urandom);
      dmem_bus.dmem_rdata  = $urandom;
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] ld_f3 [5];
    logic [2:0] st_f3 [3];
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    st_f3 = '{3'd0, 3'd1, 3'd2};
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_dmem_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
    idle_noise(2);

    // LB 0x103
    run_txn(1'b0, 3'd0, 32'h103, 32'h0, 32'h80AA_BBCC, 0, 0, 1'b0, -1);
    chk("lb_be", {28'b0, cap_be}, 32'h8);
    chk("lb_addr", cap_addr, 32'h100);
    chk("lb_rdata", cap_rdata, 32'hFFFF_FF80);
    chk("lb_latency", cap_rcyc - mA, 32'd3);

    // SH 0x202 with 3 stall cycles
    run_txn(1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 32'h0, 3, 0, 1'b0, -1);
    chk("sh_req_cycles", cap_nreq, 32'd4);
    chk("sh_be", {28'b0, cap_be}, 32'hC);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_nresp", cap_nresp, 32'd1);
    chk("sh_rdata", cap_rdata, 32'h0);

    // LW 0x005 misaligned
    run_txn(1'b0, 3'd2, 32'h005, 32'h0, 32'h0, 0, 0, 1'b0, -1);
    chk("lw_mis", {31'b0, cap_mis}, 32'd1);
    chk("lw_mis_latency", cap_rcyc - mA, 32'd1);
    chk("lw_mis_noreq", cap_nreq, 32'd0);

    // LHU / LH 0x006
    run_txn(1'b0, 3'd5, 32'h006, 32'h0, 32'h8001_0000, 0, 1, 1'b0, -1);
    chk("lhu_rdata", cap_rdata, 32'h0000_8001);
    run_txn(1'b0, 3'd1, 32'h006, 32'h0, 32'h8001_0000, 0, 1, 1'b0, -1);
    chk("lh_rdata", cap_rdata, 32'hFFFF_8001);

    // Responder never returns data; a late rvalid must not produce a response
    run_txn(1'b0, 3'd2, 32'h040, 32'h0, 32'h0, 0, 99, 1'b0, -1);
    chk("to_err", {31'b0, cap_err}, 32'd1);
    chk("to_latency", cap_rcyc - mA, 32'd10);
    dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("to_late_rvalid", cap_nresp, 32'd1);

    // Illegal funct3 on a load and an unsigned store
    run_txn(1'b0, 3'd3, 32'h010, 32'h0, 32'h0, 0, 0, 1'b0, -1);
    chk("ill_ld_err", {31'b0, cap_err}, 32'd1);
    run_txn(1'b1, 3'd4, 32'h011, 32'hFF, 32'h0, 0, 0, 1'b0, -1);
    chk("ill_st_err", {31'b0, cap_err}, 32'd1);
    chk("ill_st_latency", cap_rcyc - mA, 32'd1);

    // Reset during WAIT, then a store completes
    run_txn(1'b0, 3'd2, 32'h300, 32'h0, 32'h0, 0, 99, 1'b0, 2);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_nresp", cap_nresp, 32'd0);
    run_txn(1'b1, 3'd2, 32'h304, 32'hDEAD_BEEF, 32'h0, 1, 0, 1'b0, -1);
    chk("sw_nresp", cap_nresp, 32'd1);
    chk("sw_be", {28'b0, cap_be}, 32'hF);
    chk("sw_wdata", cap_wdata, 32'hDEAD_BEEF);

    // Randomized traffic with bus noise
    for (int i = 0; i < 200; i++) begin
      automatic bit we = 1'($urandom);
      automatic logic [2:0] f3;
      automatic logic [31:0] addr = $urandom;
      automatic int sz;
      if ($urandom % 12 == 0) f3 = 3'($urandom);
      else f3 = we ? st_f3[$urandom % 3] : ld_f3[$urandom % 5];
      sz = sz_of(f3);
      if (sz != 0 && ($urandom % 2 == 1)) addr = addr - (addr % sz);
      run_txn(we, f3, addr, $urandom, $urandom, int'($urandom % 10), int'($urandom % 10), 1'b1, -1);
      idle_noise(int'($urandom % 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
